ifid_decode: RTL and testbench

//  IF/ID pipeline register plus RV64I decode stage, directly downstream of fetch.

---
 rtl/ifid_decode.sv | 180 ++++++++++++++++++
 tb/tb_ifid_decode.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_decode.sv
// IF/ID pipeline register plus RV64I decode stage with a registered ID/EX bundle.
// Generates the fetch stall on back-pressure and load-use hazards; flushes on taken branches.
module ifid_decode #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_ack,
    input  logic [ILEN-1:0]  instr_reg,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  IFID_npc,
    input  logic             EXIF_branch,
    input  logic             IDEX_ready,
    output logic             IDIF_stall,
    output logic             IDEX_valid,
    output logic [XLEN-1:0]  IDEX_pc,
    output logic [XLEN-1:0]  IDEX_npc,
    output logic [ILEN-1:0]  IDEX_instr,
    output logic [6:0]       IDEX_opcode,
    output logic [4:0]       IDEX_rd,
    output logic [4:0]       IDEX_rs1,
    output logic [4:0]       IDEX_rs2,
    output logic [2:0]       IDEX_funct3,
    output logic [6:0]       IDEX_funct7,
    output logic [XLEN-1:0]  IDEX_imm,
    output logic             IDEX_memread,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpReg32  = 7'b0111011;

    logic             ifid_valid_q, ifid_valid_d;
    logic [ILEN-1:0]  ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0]  ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0]  ifid_npc_q, ifid_npc_d;

    logic             idex_valid_q, idex_valid_d;
    logic [ILEN-1:0]  idex_instr_q, idex_instr_d;
    logic [XLEN-1:0]  idex_pc_q, idex_pc_d;
    logic [XLEN-1:0]  idex_npc_q, idex_npc_d;
    logic [XLEN-1:0]  idex_imm_q, idex_imm_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0]       ifid_opcode;
    logic [4:0]       ifid_rs1, ifid_rs2;
    logic [XLEN-1:0]  ifid_imm;
    logic             uses_rs1, uses_rs2, hazard, id_fire;

    assign ifid_opcode = ifid_instr_q[6:0];
    assign ifid_rs1    = ifid_instr_q[19:15];
    assign ifid_rs2    = ifid_instr_q[24:20];

    assign uses_rs1 = !(ifid_opcode == OpLui || ifid_opcode == OpAuipc || ifid_opcode == OpJal);
    assign uses_rs2 = (ifid_opcode == OpReg) || (ifid_opcode == OpReg32) ||
                      (ifid_opcode == OpStore) || (ifid_opcode == OpBranch);

    // Load-use: the load sitting in ID/EX writes a register the IF/ID instruction reads.
    assign hazard = idex_valid_q && IDEX_memread && (IDEX_rd != 5'd0) &&
                    ((uses_rs1 && ifid_rs1 == IDEX_rd) || (uses_rs2 && ifid_rs2 == IDEX_rd));

    assign id_fire    = ifid_valid_q && !hazard && (!idex_valid_q || IDEX_ready);
    assign IDIF_stall = ifid_valid_q && !id_fire && !EXIF_branch;

    always_comb begin
        ifid_imm = '0;
        case (ifid_opcode)
            OpLoad, OpImm, OpImm32, OpJalr, OpSystem:
                ifid_imm = {{(XLEN-12){ifid_instr_q[31]}}, ifid_instr_q[31:20]};
            OpStore:
                ifid_imm = {{(XLEN-12){ifid_instr_q[31]}}, ifid_instr_q[31:25],
                            ifid_instr_q[11:7]};
            OpBranch:
                ifid_imm = {{(XLEN-13){ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                            ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
            OpLui, OpAuipc:
                ifid_imm = {{(XLEN-32){ifid_instr_q[31]}}, ifid_instr_q[31:12], 12'b0};
            OpJal:
                ifid_imm = {{(XLEN-21){ifid_instr_q[31]}}, ifid_instr_q[31],
                            ifid_instr_q[19:12], ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};
            default: ifid_imm = '0;
        endcase
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_npc_d   = ifid_npc_q;
        idex_valid_d = idex_valid_q;
        idex_instr_d = idex_instr_q;
        idex_pc_d    = idex_pc_q;
        idex_npc_d   = idex_npc_q;
        idex_imm_d   = idex_imm_q;
        stall_cnt_d  = stall_cnt_q + CNT_W'(IDIF_stall);
        flush_cnt_d  = flush_cnt_q + CNT_W'(EXIF_branch);

        if (EXIF_branch) begin
            ifid_valid_d = 1'b0;
        end else if (data_ack && !IDIF_stall) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = instr_reg;
            ifid_pc_d    = pc;
            ifid_npc_d   = IFID_npc;
        end else if (id_fire) begin
            ifid_valid_d = 1'b0;
        end

        if (EXIF_branch) begin
            idex_valid_d = 1'b0;
        end else if (id_fire) begin
            idex_valid_d = 1'b1;
            idex_instr_d = ifid_instr_q;
            idex_pc_d    = ifid_pc_q;
            idex_npc_d   = ifid_npc_q;
            idex_imm_d   = ifid_imm;
        end else if (IDEX_ready) begin
            idex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_npc_q   <= '0;
            idex_valid_q <= 1'b0;
            idex_instr_q <= '0;
            idex_pc_q    <= '0;
            idex_npc_q   <= '0;
            idex_imm_q   <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_npc_q   <= ifid_npc_d;
            idex_valid_q <= idex_valid_d;
            idex_instr_q <= idex_instr_d;
            idex_pc_q    <= idex_pc_d;
            idex_npc_q   <= idex_npc_d;
            idex_imm_q   <= idex_imm_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Field outputs are slices of the registered instruction, so they are registered too.
    assign IDEX_valid   = idex_valid_q;
    assign IDEX_pc      = idex_pc_q;
    assign IDEX_npc     = idex_npc_q;
    assign IDEX_instr   = idex_instr_q;
    assign IDEX_opcode  = idex_instr_q[6:0];
    assign IDEX_rd      = idex_instr_q[11:7];
    assign IDEX_rs1     = idex_instr_q[19:15];
    assign IDEX_rs2     = idex_instr_q[24:20];
    assign IDEX_funct3  = idex_instr_q[14:12];
    assign IDEX_funct7  = idex_instr_q[31:25];
    assign IDEX_imm     = idex_imm_q;
    assign IDEX_memread = (idex_instr_q[6:0] == OpLoad);
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_ifid_decode.sv
// Scoreboard bench for ifid_decode: directed instructions with hand-computed decode results.
module tb_ifid_decode;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             data_ack = 1'b0;
    logic [ILEN-1:0]  instr_reg = '0;
    logic [XLEN-1:0]  pc = '0;
    logic [XLEN-1:0]  IFID_npc = '0;
    logic             EXIF_branch = 1'b0;
    logic             IDEX_ready = 1'b1;
    logic             IDIF_stall;
    logic             IDEX_valid;
    logic [XLEN-1:0]  IDEX_pc, IDEX_npc, IDEX_imm;
    logic [ILEN-1:0]  IDEX_instr;
    logic [6:0]       IDEX_opcode, IDEX_funct7;
    logic [4:0]       IDEX_rd, IDEX_rs1, IDEX_rs2;
    logic [2:0]       IDEX_funct3;
    logic             IDEX_memread;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    ifid_decode #(.XLEN(XLEN), .ILEN(ILEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .data_ack(data_ack), .instr_reg(instr_reg), .pc(pc),
        .IFID_npc(IFID_npc), .EXIF_branch(EXIF_branch), .IDEX_ready(IDEX_ready),
        .IDIF_stall(IDIF_stall), .IDEX_valid(IDEX_valid), .IDEX_pc(IDEX_pc),
        .IDEX_npc(IDEX_npc), .IDEX_instr(IDEX_instr), .IDEX_opcode(IDEX_opcode),
        .IDEX_rd(IDEX_rd), .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2),
        .IDEX_funct3(IDEX_funct3), .IDEX_funct7(IDEX_funct7), .IDEX_imm(IDEX_imm),
        .IDEX_memread(IDEX_memread), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            mr;
    } exp_t;

    exp_t            exp_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [XLEN-1:0] pc_r = 64'h1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one instruction to the DUT and hold it until fetch is allowed to advance.
    task automatic issue(input logic [31:0] ins, input logic [63:0] imm, input logic [4:0] rd,
                         input logic mr);
        bit   acc = 1'b0;
        exp_t e;
        @(negedge clk);
        data_ack  = 1'b1;
        instr_reg = ins;
        pc        = pc_r;
        IFID_npc  = pc_r + 64'd4;
        for (int k = 0; k < 20 && !acc; k++) begin
            #1;
            acc = !IDIF_stall && !EXIF_branch;
            if (acc) begin
                e.pc = pc_r; e.instr = ins; e.imm = imm; e.rd = rd; e.mr = mr;
                exp_q.push_back(e);
                pc_r = pc_r + 64'd4;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!acc) chk("issue_timeout", 64'(IDIF_stall), 64'd0);
    endtask

    task automatic idle();
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    // Monitor: every accepted ID/EX bundle is checked against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && IDEX_valid && IDEX_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", 64'(IDEX_instr), 64'(e.instr));
                    chk("sb_pc", IDEX_pc, e.pc);
                    chk("sb_npc", IDEX_npc, e.pc + 64'd4);
                    chk("sb_imm", IDEX_imm, e.imm);
                    chk("sb_rd", 64'(IDEX_rd), 64'(e.rd));
                    chk("sb_memread", 64'(IDEX_memread), 64'(e.mr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(IDEX_valid), 64'd0);
        chk("rst_stall", 64'(IDIF_stall), 64'd0);
        chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("rst_flush_count", 64'(flush_count), 64'd0);
        chk("rst_imm", IDEX_imm, 64'd0);
        reset = 1'b0;

        // addi x5,x0,-1: bundle appears two edges after presentation
        issue(32'hFFF00293, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b0);
        idle();
        #1;
        chk("t1_not_yet", 64'(IDEX_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("t1_valid", 64'(IDEX_valid), 64'd1);
        chk("t1_imm", IDEX_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_rd", 64'(IDEX_rd), 64'd5);

        // ld x6,0(x1); add x7,x6,x2 -> one bubble
        issue(32'h0000B303, 64'd0, 5'd6, 1'b1);
        issue(32'h002303B3, 64'd0, 5'd7, 1'b0);
        idle();
        #1;
        chk("t2_stall", 64'(IDIF_stall), 64'd1);
        chk("t2_ld_memread", 64'(IDEX_memread), 64'd1);
        chk("t2_ld_funct3", 64'(IDEX_funct3), 64'd3);
        chk("t2_ld_opcode", 64'(IDEX_opcode), 64'h03);
        @(negedge clk);
        #1;
        chk("t2_bubble", 64'(IDEX_valid), 64'd0);
        chk("t2_stall_gone", 64'(IDIF_stall), 64'd0);
        @(negedge clk);
        #1;
        chk("t2_add_valid", 64'(IDEX_valid), 64'd1);
        chk("t2_add_instr", 64'(IDEX_instr), 64'h002303B3);
        chk("t2_add_rs1", 64'(IDEX_rs1), 64'd6);
        chk("t2_add_rs2", 64'(IDEX_rs2), 64'd2);
        chk("t2_add_funct7", 64'(IDEX_funct7), 64'd0);
        chk("t2_stall_cycles", 64'(stall_cycles), 64'd1);

        // ld x0,0(x1); add x7,x0,x2 -> x0 destination never stalls
        issue(32'h0000B003, 64'd0, 5'd0, 1'b1);
        issue(32'h002003B3, 64'd0, 5'd7, 1'b0);
        idle();
        #1;
        chk("t3_no_stall", 64'(IDIF_stall), 64'd0);
        @(negedge clk);
        #1;
        chk("t3_no_bubble", 64'(IDEX_instr), 64'h002003B3);
        chk("t3_stall_cycles", 64'(stall_cycles), 64'd1);

        // Immediate formats and edges
        issue(32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 1'b0);  // jal x1,-4
        issue(32'h000000E3, 64'h0000_0000_0000_0800, 5'd1, 1'b0);  // beq +2048
        issue(32'h800000E3, 64'hFFFF_FFFF_FFFF_F800, 5'd1, 1'b0);  // beq -2048
        issue(32'h8020A023, 64'hFFFF_FFFF_FFFF_F800, 5'd0, 1'b0);  // sw x2,-2048(x1)
        issue(32'h7E20AFA3, 64'h0000_0000_0000_07FF, 5'd31, 1'b0); // sw x2,2047(x1)
        issue(32'h123451B7, 64'h0000_0000_1234_5000, 5'd3, 1'b0);  // lui x3,0x12345
        issue(32'h800001B7, 64'hFFFF_FFFF_8000_0000, 5'd3, 1'b0);  // lui x3,0x80000
        idle();
        repeat (3) @(negedge clk);

        // Back-pressure: ID/EX held for three cycles
        IDEX_ready = 1'b0;
        issue(32'h00500413, 64'd5, 5'd8, 1'b0);                    // addi x8,x0,5
        issue(32'h80000493, 64'hFFFF_FFFF_FFFF_F800, 5'd9, 1'b0);  // addi x9,x0,-2048
        idle();
        for (int c = 0; c < 3; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            chk("t4_stall", 64'(IDIF_stall), 64'd1);
            chk("t4_hold_instr", 64'(IDEX_instr), 64'h00500413);
            chk("t4_hold_imm", IDEX_imm, 64'd5);
        end
        @(negedge clk);
        IDEX_ready = 1'b1;
        #1;
        chk("t4_release", 64'(IDIF_stall), 64'd0);
        chk("t4_stall_cycles", 64'(stall_cycles), 64'd4);
        repeat (3) @(negedge clk);

        // Taken branch with both slots full
        IDEX_ready = 1'b0;
        issue(32'h00100513, 64'd1, 5'd10, 1'b0);                   // addi x10,x0,1
        issue(32'h00200593, 64'd2, 5'd11, 1'b0);                   // addi x11,x0,2
        @(negedge clk);
        data_ack    = 1'b0;
        EXIF_branch = 1'b1;
        #1;
        chk("t5_stall_masked", 64'(IDIF_stall), 64'd0);
        @(negedge clk);
        EXIF_branch = 1'b0;
        #1;
        chk("t5_idex_flushed", 64'(IDEX_valid), 64'd0);
        chk("t5_flush_count", 64'(flush_count), 64'd1);
        chk("t5_stall_cycles", 64'(stall_cycles), 64'd4);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        IDEX_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t5_slot_empty", 64'(IDEX_valid), 64'd0);
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        // Reset while both slots hold instructions
        IDEX_ready = 1'b0;
        issue(32'h00300613, 64'd3, 5'd12, 1'b0);
        issue(32'h00400693, 64'd4, 5'd13, 1'b0);
        @(negedge clk);
        data_ack = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_valid", 64'(IDEX_valid), 64'd0);
        chk("t6_stall", 64'(IDIF_stall), 64'd0);
        chk("t6_instr", 64'(IDEX_instr), 64'd0);
        chk("t6_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("t6_flush_count", 64'(flush_count), 64'd0);
        exp_q.delete();
        reset      = 1'b0;
        IDEX_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_stays_empty", 64'(IDEX_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
